// File: rtl/sev_seg_scan.sv
// Multiplexed seven-segment display scanner.
// A free-running divider sets the digit period. The display contents are
// double-buffered so that a new value only takes effect at a frame boundary.
// Each digit period starts with a short anode-off gap to suppress ghosting.
module sev_seg_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP         = 4,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_act_val;
  logic [DIGITS-1:0]   r_act_dp;
  logic [4*DIGITS-1:0] r_pend_val;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_flag;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_dec;
  logic [DIGITS-1:0]   w_zero_above;
  logic                w_run;
  logic                w_blank;

  assign w_tick = (r_div == DIV_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Digit period divider and scan index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pending, pending moves to active only at a frame wrap.
  // A load in the wrap cycle still transfers the older pending contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      if (w_wrap && r_pend_flag) begin
        r_act_val   <= r_pend_val;
        r_act_dp    <= r_pend_dp;
        r_pend_flag <= 1'b0;
      end
      if (load) begin
        r_pend_val  <= value;
        r_pend_dp   <= dp_in;
        r_pend_flag <= 1'b1;
      end
    end
  end

  // Flag digits whose nibble and every more-significant nibble are zero.
  always_comb begin
    w_zero_above = '0;
    w_run        = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run           = w_run & (r_act_val[4*k +: 4] == 4'h0);
      w_zero_above[k] = w_run;
    end
  end

  assign w_nib   = r_act_val[4*r_idx +: 4];
  assign w_blank = ~digit_en[r_idx] | (lz_blank & (r_idx != '0) & w_zero_above[r_idx]);

  // Hex to active-low segments, bit order a..g from MSB to LSB.
  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_nib)
      4'h0: w_seg_dec = 7'b0000001;
      4'h1: w_seg_dec = 7'b1001111;
      4'h2: w_seg_dec = 7'b0010010;
      4'h3: w_seg_dec = 7'b0000110;
      4'h4: w_seg_dec = 7'b1001100;
      4'h5: w_seg_dec = 7'b0100100;
      4'h6: w_seg_dec = 7'b0100000;
      4'h7: w_seg_dec = 7'b0001111;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0000100;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b1100000;
      4'hC: w_seg_dec = 7'b0110001;
      4'hD: w_seg_dec = 7'b1000010;
      4'hE: w_seg_dec = 7'b0110000;
      4'hF: w_seg_dec = 7'b0111000;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  // Registered display outputs; segments stay valid through the gap so only the anode switches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_blank) begin
        r_seg <= 7'b1111111;
        r_dp  <= 1'b1;
        r_an  <= '1;
      end else begin
        r_seg <= w_seg_dec;
        r_dp  <= ~r_act_dp[r_idx];
        r_an  <= (r_div < GAP_C) ? '1 : ~(DIGITS'(1) << r_idx);
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign scan_idx   = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan with DIGITS=4, REFRESH_DIV=4, GAP=1.
// A cycle-based reference model derives each expected output from the time
// elapsed since reset and the frame-buffered display contents.
module tb_sev_seg_scan;

  localparam int DG = 4;
  localparam int RD = 4;
  localparam int GP = 1;
  localparam int FRAME = DG * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_done;

  sev_seg_scan #(.DIGITS(DG), .REFRESH_DIV(RD), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: s = cycles elapsed since reset as seen by the next clock edge.
  int          s = 0;
  bit          mvalid = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
  bit          m_flag = 0;

  always @(posedge clk) begin
    exp_t       e;
    int         pos, dig;
    logic [3:0] nib;
    bit         blank;
    if (!rst_n) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.idx = 2'd0;
      s = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_flag = 0;
      mvalid = 1;
      q.push_back(e);
    end else if (mvalid) begin
      pos   = s % RD;
      dig   = (s / RD) % DG;
      nib   = m_act[4*dig +: 4];
      blank = !digit_en[dig] || (lz_blank && dig > 0 && (m_act >> (4*dig)) == 16'h0);
      if (blank) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.seg = seg_tab[nib];
        e.dp  = ~m_act_dp[dig];
        e.an  = (pos < GP) ? 4'hF : ~(4'b0001 << dig);
      end
      e.fd = ((s % FRAME) == FRAME - 1);
      if (e.fd && m_flag) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_flag = 0;
      end
      if (load) begin
        m_pend = value; m_pend_dp = dp_in; m_flag = 1;
      end
      s++;
      e.idx = 2'((s / RD) % DG);
      q.push_back(e);
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Monitor: outputs settle after each rising edge, checked on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("dp", 32'(dp), 32'(e.dp));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("scan_idx", 32'(scan_idx), 32'(e.idx));
    end
  end

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    @(negedge clk);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Leaves the bench at the negedge before the cycle whose model phase equals ph.
  task automatic wait_phase(int ph);
    int i;
    for (i = 0; i < 64 && (s % FRAME) != ph; i++) @(negedge clk);
    if ((s % FRAME) != ph) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_phase: phase %0d expected %0d", s % FRAME, ph);
    end
  endtask

  initial begin
    logic [31:0] r;
    cycles(3);
    rst_n = 1'b1;

    // Plain display of 1234.
    do_load(16'h1234, 4'h0);
    cycles(40);

    // Leading-zero suppression.
    lz_blank = 1'b1;
    do_load(16'h0050, 4'h0);
    cycles(40);

    // Digit 2 disabled.
    digit_en = 4'b1011;
    cycles(36);

    // Load coinciding with the wrap tick while 1111 is pending.
    digit_en = 4'hF;
    lz_blank = 1'b0;
    @(negedge clk);
    wait_phase(5);
    value = 16'h1111; dp_in = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_phase(FRAME - 1);
    value = 16'hABCD; dp_in = 4'h5; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cycles(40);

    // Reset mid-frame with a load pending.
    wait_phase(2);
    value = 16'h5678; dp_in = 4'hA; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(50);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      r = $urandom;
      value = r[15:0] >> (4 * $urandom_range(0, 4));
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 39) == 0) lz_blank = 1'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
